// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Word length select code to number of data bits.
    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        logic [3:0] n;
        case (wls)
            WLS_5:   n = 4'd5;
            WLS_6:   n = 4'd6;
            WLS_7:   n = 4'd7;
            WLS_8:   n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Parity mismatch: even parity (eps=1) wants an even count of ones
    // across data+parity, odd parity (eps=0) wants an odd count.
    function automatic logic parity_calc(input logic data_xor,
                                         input logic par_bit,
                                         input logic eps);
        return data_xor ^ par_bit ^ ~eps;
    endfunction

endpackage

// File: rtl/uart_rx_voter.sv
// Synchronizes rxd, detects its falling edge and majority-votes each bit.
// Latency: SYNC_STAGES cycles rxd->rxd_sync; bit decision combinational on sample_edge.
// Backpressure: none; strobes from the edge generator are consumed as they arrive.
module uart_rx_voter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic preset,
    input  logic rxd,
    input  logic voting_edge,
    input  logic sample_edge,
    output logic rxd_sync,
    output logic rxd_fall,
    output logic bit_val,
    output logic bit_strobe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [1:0]             votes_q;
    logic [1:0]             votes_d;

    assign rxd_sync   = sync_q[SYNC_STAGES-1];
    assign rxd_fall   = prev_q & ~rxd_sync;
    assign bit_strobe = sample_edge;
    // Two or three of the three votes high means the bit is 1.
    assign bit_val    = votes_q[1];

    // Vote accumulator: sample_edge clears it and takes priority over a vote.
    always_comb begin
        votes_d = votes_q;
        if (sample_edge) begin
            votes_d = 2'd0;
        end else if (voting_edge) begin
            votes_d = votes_q + {1'b0, rxd_sync};
        end
    end

    // Synchronizer chain, edge-detect history and vote register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            votes_q <= 2'd0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
            prev_q  <= rxd_sync;
            votes_q <= votes_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// Turns voted serial bits into parallel characters with parity/framing/break status.
// Latency: rx_valid one cycle after the stop-bit sample_edge.
// Backpressure: none; rx_valid is a single-cycle pulse the consumer must accept.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  rxd,
    input  logic                  voting_edge,
    input  logic                  sample_edge,
    input  logic [1:0]            wls,
    input  logic                  pen,
    input  logic                  eps,
    output logic                  sample_clk_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_err,
    output logic                  rx_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic rxd_sync;
    logic rxd_fall;
    logic bit_val;
    logic bit_strobe;

    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            nbits_q, nbits_d;
    logic                  pen_q, pen_d;
    logic                  eps_q, eps_d;
    logic                  par_q, par_d;
    logic                  clr_q, clr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  berr_q, berr_d;

    uart_rx_voter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_voter (
        .pclk       (pclk),
        .preset     (preset),
        .rxd        (rxd),
        .voting_edge(voting_edge),
        .sample_edge(sample_edge),
        .rxd_sync   (rxd_sync),
        .rxd_fall   (rxd_fall),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe)
    );

    assign sample_clk_clr = clr_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign parity_err     = perr_q;
    assign framing_err    = ferr_q;
    assign break_err      = berr_q;
    assign rx_busy        = (state_q != RX_IDLE);

    // Frame FSM next-state, data assembly and end-of-frame status.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        par_d      = par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        berr_d     = berr_q;

        case (state_q)
            RX_IDLE: begin
                // A fall always leaves the synced line low; both are checked
                // so entry is tied to the level the voter will start from.
                if (rxd_fall && !rxd_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (bit_strobe) begin
                    if (bit_val) begin
                        state_d = RX_IDLE;
                    end else begin
                        // Frame format is frozen here for the whole character.
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        nbits_d   = wls_to_bits(wls);
                        pen_d     = pen;
                        eps_d     = eps;
                        par_d     = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (bit_strobe) begin
                    shift_d[bit_cnt_q] = bit_val;
                    bit_cnt_d          = bit_cnt_q + 1'b1;
                    if (int'(bit_cnt_q) == int'(nbits_q) - 1) begin
                        state_d = pen_q ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (bit_strobe) begin
                    par_d   = bit_val;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_strobe) begin
                    state_d    = RX_IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = shift_q;
                    ferr_d     = ~bit_val;
                    berr_d     = (shift_q == '0) & ~(pen_q & par_q) & ~bit_val;
                    // A break is not a character, so parity is not reported on it.
                    perr_d     = pen_q & parity_calc(^shift_q, par_q, eps_q) & ~berr_d;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Edge generator counter is held whenever the FSM is (or returns to) idle.
        clr_d = (state_d == RX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            nbits_q    <= 4'd0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            par_q      <= 1'b0;
            clr_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            par_q      <= par_d;
            clr_q      <= clr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            berr_q     <= berr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: drives vote/sample strobes by hand.
// Latency: checks rx_valid one cycle after the stop-bit sample strobe.
// Backpressure: none; rx_valid pulses are counted on the falling clock edge.
module tb_uart_rx_deframer;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       rxd = 1'b1;
    logic       voting_edge = 1'b0;
    logic       sample_edge = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sample_clk_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_err;
    logic       rx_busy;

    int total = 0;
    int bad = 0;
    int nvalid = 0;
    int base = 0;

    uart_rx_deframer #(
        .SYNC_STAGES(2),
        .DATA_WIDTH (8)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .rxd           (rxd),
        .voting_edge   (voting_edge),
        .sample_edge   (sample_edge),
        .wls           (wls),
        .pen           (pen),
        .eps           (eps),
        .sample_clk_clr(sample_clk_clr),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_err    (parity_err),
        .framing_err   (framing_err),
        .break_err     (break_err),
        .rx_busy       (rx_busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (rx_valid === 1'b1) nvalid++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, leaving time 1 unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic vote(input logic v);
        rxd = v;
        cyc(4);
        voting_edge = 1'b1;
        cyc(1);
        voting_edge = 1'b0;
    endtask

    // Three votes (v[0] first) then the decision strobe.
    task automatic send_bit3(input logic [2:0] v);
        vote(v[0]);
        vote(v[1]);
        vote(v[2]);
        sample_edge = 1'b1;
        cyc(1);
        sample_edge = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        send_bit3({3{b}});
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic use_par,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        logic [7:0] ch;

        // Reset state
        cyc(3);
        check("rst_clr", sample_clk_clr, 1);
        check("rst_busy", rx_busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_errs", {parity_err, framing_err, break_err}, 0);
        preset = 1'b0;
        cyc(2);

        // 8N1 0xA5, clean votes
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        base = nvalid;
        vote(1'b0);
        check("start_clr_low", sample_clk_clr, 0);
        check("start_busy", rx_busy, 1);
        vote(1'b0);
        vote(1'b0);
        sample_edge = 1'b1; cyc(1); sample_edge = 1'b0;
        ch = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(ch[i]);
        send_bit(1'b1);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_errs", {parity_err, framing_err, break_err}, 0);
        check("a5_clr", sample_clk_clr, 1);
        check("a5_busy", rx_busy, 0);
        cyc(1);
        check("a5_valid_pulse", rx_valid, 0);
        check("a5_data_hold", rx_data, 8'hA5);
        cyc(1);
        check("a5_count", nvalid - base, 1);

        // 7E1 0x35 with wrong parity bit; format inputs change mid-frame
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        base = nvalid;
        send_bit(1'b0);
        wls = 2'b00; pen = 1'b0; eps = 1'b0;
        ch = 8'h35;
        for (int i = 0; i < 7; i++) send_bit(ch[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        check("7e1_valid", rx_valid, 1);
        check("7e1_data", rx_data, 8'h35);
        check("7e1_perr", parity_err, 1);
        check("7e1_ferr", framing_err, 0);
        check("7e1_berr", break_err, 0);
        cyc(2);
        check("7e1_count", nvalid - base, 1);

        // 5N1 0x1F, one vote flipped per bit
        wls = 2'b00; pen = 1'b0; eps = 1'b0;
        base = nvalid;
        send_bit3(3'b010);
        send_bit3(3'b110);
        send_bit3(3'b101);
        send_bit3(3'b011);
        send_bit3(3'b110);
        send_bit3(3'b101);
        send_bit3(3'b101);
        check("5n1_valid", rx_valid, 1);
        check("5n1_data", rx_data, 8'h1F);
        check("5n1_errs", {parity_err, framing_err, break_err}, 0);
        cyc(2);
        check("5n1_count", nvalid - base, 1);

        // Glitch during start bit: votes 0,1,1 -> false start
        base = nvalid;
        send_bit3(3'b110);
        check("glitch_busy", rx_busy, 0);
        check("glitch_clr", sample_clk_clr, 1);
        check("glitch_valid", rx_valid, 0);
        cyc(2);
        check("glitch_count", nvalid - base, 0);
        check("glitch_data_hold", rx_data, 8'h1F);

        // 8O1 with the line held low for the whole frame -> break
        wls = 2'b11; pen = 1'b1; eps = 1'b0;
        base = nvalid;
        send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0);
        check("brk_valid", rx_valid, 1);
        check("brk_data", rx_data, 8'h00);
        check("brk_berr", break_err, 1);
        check("brk_ferr", framing_err, 1);
        check("brk_perr", parity_err, 0);
        cyc(6);
        check("brk_stuck_idle", rx_busy, 0);
        check("brk_count", nvalid - base, 1);
        rxd = 1'b1;
        cyc(6);

        // Reset during data bit 3 of 0x3C, then a clean 0x3C frame
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        base = nvalid;
        ch = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(ch[i]);
        vote(ch[3]);
        preset = 1'b1;
        cyc(1);
        check("mrst_clr", sample_clk_clr, 1);
        check("mrst_busy", rx_busy, 0);
        check("mrst_valid", rx_valid, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_errs", {parity_err, framing_err, break_err}, 0);
        preset = 1'b0;
        rxd = 1'b1;
        cyc(6);
        check("mrst_count", nvalid - base, 0);
        send_frame(ch, 8, 1'b0, 1'b0, 1'b1);
        check("3c_valid", rx_valid, 1);
        check("3c_data", rx_data, 8'h3C);
        check("3c_errs", {parity_err, framing_err, break_err}, 0);
        cyc(2);
        check("3c_count", nvalid - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side consumer of the UART baud edge generator: turns the serial rxd line into parallel characters.
- Uses voting_edge (3 pulses per bit, at sub-bit counts 6/7/8) and sample_edge (1 pulse per bit, count 9) to majority-vote each bit.
- Drives sample_clk_clr back to the edge generator to hold its receive counter in reset while idle and re-phase it on each start bit.
- Sits between the LCR register fields and the RX FIFO write port.

Parameters:
- SYNC_STAGES, 2, number of rxd synchronizer flops (min 2)
- DATA_WIDTH, 8, max character width; rx_data width

Ports:
- pclk  input  1  system clock
- preset  input  1  synchronous active-high reset
- rxd  input  1  asynchronous serial input, idle high
- voting_edge  input  1  one-cycle vote strobe from edge generator
- sample_edge  input  1  one-cycle bit-decision strobe from edge generator
- wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- pen  input  1  parity enable
- eps  input  1  even parity select (1=even, 0=odd)
- sample_clk_clr  output  1  holds/clears edge generator receive counter
- rx_data  output  DATA_WIDTH  received character, LSB-aligned, unused MSBs zero
- rx_valid  output  1  one-cycle pulse: rx_data and status valid
- parity_err  output  1  parity mismatch for current character (valid with rx_valid)
- framing_err  output  1  first stop bit sampled 0 (valid with rx_valid)
- break_err  output  1  data, parity and stop all 0 (valid with rx_valid)
- rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous and active-high on preset, sampled on the pclk rising edge.
- Reset values:
  - Synchronizer chain all 1.
  - state=IDLE, sample_clk_clr=1.
  - rx_data=0; rx_valid, parity_err, framing_err, break_err, rx_busy all 0.
  - Vote counter and bit counter 0.
- Reset mid-frame: abandons the partial character, emits no rx_valid, and returns to the reset values the next cycle.
- rxd path: passes through SYNC_STAGES flops. Falling edge = previous synced value 1, current 0.
- Voting:
  - A 2-bit vote accumulator adds the synced rxd on each voting_edge.
  - On sample_edge, bit value = (votes >= 2). The accumulator clears in the same cycle.
  - voting_edge and sample_edge are never coincident. If both arrive together, sample_edge wins and the vote is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: sample_clk_clr=1. On a synced falling edge go to START; sample_clk_clr=0 from the next cycle.
  - START: on sample_edge:
    - bit=1: false start, return to IDLE with sample_clk_clr=1.
    - bit=0: go to DATA, bit counter=0.
  - DATA: on each sample_edge, shift the bit into position bit counter (LSB first) and increment.
    - After bit (wls+5)-1, go to PARITY if pen=1, else STOP.
  - PARITY: on sample_edge, capture the parity bit and go to STOP.
  - STOP: on sample_edge, evaluate the frame, go to IDLE and set sample_clk_clr=1 in the same transition.
    - Only the first stop bit is checked. The next falling edge in IDLE may start a new frame immediately.
- Output timing: rx_valid pulses the cycle after the STOP sample_edge. rx_data and all three error flags update in that same cycle and hold until the next rx_valid.
- Error flags:
  - parity_err = pen & (XOR(data bits, parity bit) != ~eps). Even parity requires an even count of ones across data+parity.
  - framing_err = stop bit 0.
  - break_err = all data bits 0, parity bit 0 (if pen), and stop bit 0. framing_err is also set.
- Timing rules:
  - wls and pen/eps are sampled once, on the START->DATA transition. Changes mid-frame have no effect.
  - No timeout: a stuck-low line repeats break frames, each gated by a falling edge.

Decomposition:
- uart_pkg:
  - rx_state_t enum
  - WLS_5..WLS_8 codes
  - function wls_to_bits (returns 5..8)
  - function parity_calc
- Sub-module uart_rx_voter: synchronizer, falling-edge detect, vote accumulator, bit decision.
  - Ports: pclk, preset, rxd, voting_edge, sample_edge, rxd_sync, rxd_fall, bit_val, bit_strobe.

Test Plan:
- 8N1, char 0xA5, votes all clean -> rx_valid once, rx_data=0xA5, all error flags 0, sample_clk_clr back to 1 the cycle after the STOP sample_edge.
- 7E1 (wls=10, pen=1, eps=1), char 0x35 with bad parity bit 1 -> rx_data=0x35, parity_err=1, framing_err=0.
- 5N1, char 0x1F, one of three votes flipped on each bit -> rx_data=0x1F, upper bits 0, no errors.
- Glitch: rxd low for one vote only during START (votes 0,1,1) -> no rx_valid, back to IDLE, sample_clk_clr=1.
- 8O1 line held low for the whole frame -> rx_data=0x00, break_err=1, framing_err=1, parity_err=0.
- Assert preset during DATA bit 3 -> no rx_valid; all outputs at reset values next cycle; a following clean 0x3C frame is received correctly.
